// File: rtl/mod_div_sm2.sv
// Sequential modular divider q = a * b^-1 mod P (binary extended Euclid),
// one reduction step per clock, start/done handshake.
module mod_div_sm2 #(
    parameter int              WIDTH = 256,
    parameter logic [WIDTH-1:0] P    = 256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] q
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_CHECK = 2'd1;
    localparam logic [1:0]  S_ITER  = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;
    localparam logic [10:0] GUARD   = 11'(4 * WIDTH);
    localparam logic [WIDTH:0] P_EXT = {1'b0, P};

    // x/2 mod P: odd values get P added first so the shift is exact.
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + P_EXT) : {1'b0, x};
        return s[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[WIDTH] ? (d[WIDTH-1:0] + P) : d[WIDTH-1:0];
    endfunction

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] u_reg, v_reg, x1_reg, x2_reg;
    logic [10:0]      cnt_reg;
    logic [WIDTH-1:0] res_reg;
    logic             res_err_reg;
    logic             busy_reg, done_reg, err_reg;
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            u_reg       <= '0;
            v_reg       <= '0;
            x1_reg      <= '0;
            x2_reg      <= '0;
            cnt_reg     <= '0;
            res_reg     <= '0;
            res_err_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            q_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // done_reg high means we are in the done cycle; start is ignored there
                    if (start && !done_reg) begin
                        u_reg     <= b;
                        v_reg     <= P;
                        x1_reg    <= a;
                        x2_reg    <= '0;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (u_reg == '0 || x1_reg >= P || u_reg >= P) begin
                        res_reg     <= '0;
                        res_err_reg <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        state_reg <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (u_reg == WIDTH'(1)) begin
                        res_reg     <= x1_reg;
                        res_err_reg <= 1'b0;
                        state_reg   <= S_DONE;
                    end else if (v_reg == WIDTH'(1)) begin
                        res_reg     <= x2_reg;
                        res_err_reg <= 1'b0;
                        state_reg   <= S_DONE;
                    end else if (cnt_reg == GUARD) begin
                        res_reg     <= '0;
                        res_err_reg <= 1'b1;
                        state_reg   <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 11'd1;
                        if (!u_reg[0]) begin
                            u_reg  <= u_reg >> 1;
                            x1_reg <= half_mod(x1_reg);
                        end else if (!v_reg[0]) begin
                            v_reg  <= v_reg >> 1;
                            x2_reg <= half_mod(x2_reg);
                        end else if (u_reg >= v_reg) begin
                            u_reg  <= u_reg - v_reg;
                            x1_reg <= sub_mod(x1_reg, x2_reg);
                        end else begin
                            v_reg  <= v_reg - u_reg;
                            x2_reg <= sub_mod(x2_reg, x1_reg);
                        end
                    end
                end
                default: begin
                    q_reg     <= res_reg;
                    err_reg   <= res_err_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;
    assign q    = q_reg;

endmodule
